mem_req_arbiter_n: RTL and testbench
====================================

MEM_REQ_ARBITER_N -- requirements
Module: mem_req_arbiter_n

Interface
REQ-001 Parameters SHALL be:
- XLEN, default 32, address/data width.
- NUM_PORTS, default 2, requester count (1..8).
- ARB_MODE, default 1, arbitration policy: 0 = fixed priority, 1 = round-robin.
- CNT_W, default 32, performance counter width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- req_valid, in, NUM_PORTS, per-port request valid.
- req_ready, out, NUM_PORTS, per-port request accept.
- req_addr, in, NUM_PORTS*XLEN, per-port address; port i in slice i.
- req_we, in, NUM_PORTS, per-port write enable.
- req_size, in, NUM_PORTS*2, per-port access size.
- req_wdata, in, NUM_PORTS*XLEN, per-port write data.
- rsp_valid, out, NUM_PORTS, per-port one-cycle response strobe.
- rsp_rdata, out, XLEN, response data, shared by all ports.
- mem_req_valid, out, 1, downstream request valid.
- mem_req_ready, in, 1, downstream request accept.
- mem_addr / mem_we / mem_size / mem_wdata, out, XLEN / 1 / 2 / XLEN, downstream request fields.
- mem_rsp_valid, in, 1, downstream response strobe.
- mem_rsp_rdata, in, XLEN, downstream response data.
- grant_id, out, max(1,$clog2(NUM_PORTS)), owner of the in-flight transaction.
- busy, out, 1, high when state is not IDLE.
- protocol_err, out, 1, sticky unexpected-response flag.
- perf_grant_cnt, out, NUM_PORTS*CNT_W, per-port grant counters.
- perf_stall_cnt, out, NUM_PORTS*CNT_W, per-port stall counters.

Function
REQ-003 The block SHALL hold exactly one outstanding transaction, using an FSM with states IDLE, ISSUE and WAIT_RSP.
REQ-004 In IDLE, req_ready SHALL be driven combinationally one-hot to the arbitration winner among asserted req_valid bits, and SHALL be all-zero in every other state.
REQ-005 On a valid&ready handshake the block SHALL register addr/we/size/wdata and the winner index into grant_id, then enter ISSUE on the next edge.
REQ-006 In ISSUE, mem_req_valid SHALL be 1 with fields held stable until mem_req_ready is sampled high; the FSM SHALL then enter WAIT_RSP.
REQ-007 In WAIT_RSP, a sampled mem_rsp_valid SHALL produce, on the following cycle, rsp_valid[grant_id]=1 for exactly one cycle with rsp_rdata equal to the captured mem_rsp_rdata, and the FSM SHALL return to IDLE on that same edge.
REQ-008 A new request SHALL be acceptable in the cycle rsp_valid is high; minimum accept-to-accept spacing SHALL therefore be 3 cycles with zero downstream wait.
REQ-009 ARB_MODE=0: the lowest asserted index SHALL win.
REQ-010 ARB_MODE=1: the search SHALL start at (last_grant+1) modulo NUM_PORTS and wrap; last_grant SHALL update only on a handshake.
REQ-011 mem_rsp_valid sampled in IDLE or ISSUE SHALL be ignored for data purposes and SHALL set protocol_err, which stays set until reset.
REQ-012 Deasserting req_valid before a handshake SHALL NOT change state; the arbiter SHALL re-evaluate every IDLE cycle.
REQ-013 With NUM_PORTS=1 the block SHALL behave as a registered pass-through; grant_id SHALL be constant 0.
REQ-014 rsp_rdata SHALL hold its last value when rsp_valid is low.

Reset
REQ-015 Asserting reset_n low SHALL asynchronously force:
- state = IDLE
- req_ready = 0, rsp_valid = 0, mem_req_valid = 0
- grant_id = 0, busy = 0, protocol_err = 0
- rsp_rdata = 0 and all mem_* fields = 0
- last_grant = NUM_PORTS-1
- all counters = 0
REQ-016 A reset during ISSUE or WAIT_RSP SHALL abandon the transaction with no rsp_valid emitted; a late mem_rsp_valid after reset SHALL set protocol_err.

Configuration
REQ-017 Macro MEM_ARB_PERF_EN defined: perf_grant_cnt[i] SHALL increment on each port-i handshake, and perf_stall_cnt[i] SHALL increment on each cycle with req_valid[i]&!req_ready[i]; both SHALL saturate at all-ones.
REQ-018 Macro MEM_ARB_PERF_EN undefined: no counter flops SHALL be generated and both perf outputs SHALL be constant 0.

Verification
REQ-019 Directed scenarios:
- Single read: port 0 read addr 0x100, mem_req_ready=1, response 0xDEADBEEF two cycles later -> rsp_valid[0] one cycle later, rsp_rdata=0xDEADBEEF, busy back to 0.
- RR fairness: NUM_PORTS=3, ARB_MODE=1, all ports valid continuously for 6 transactions -> grant order 0,1,2,0,1,2.
- Fixed priority: ARB_MODE=0, ports 0 and 1 valid continuously -> port 0 granted every time; perf_stall_cnt[1] increments every cycle.
- Downstream backpressure: mem_req_ready low 5 cycles -> mem_addr/mem_wdata stable throughout and no req_ready asserted.
- Stray response: mem_rsp_valid pulsed in IDLE -> protocol_err=1, no rsp_valid; stays 1 until reset_n low.
- Reset mid-WAIT_RSP: reset_n low for 1 cycle -> all outputs 0, no rsp_valid; next request served normally.

Source files
------------

// File: rtl/mem_req_arbiter_n.sv
// mem_req_arbiter_n: NUM_PORTS requesters share one memory port, one transaction in flight.
// Defining MEM_ARB_PERF_EN adds saturating per-port grant/stall counters; otherwise perf outputs are 0.
//
// state    | meaning
// IDLE     | arbitrating; req_ready one-hot to the winner
// ISSUE    | mem_req_valid high, fields held until mem_req_ready
// WAIT_RSP | downstream accepted, waiting for mem_rsp_valid

module mem_req_arbiter_n #(
  parameter int XLEN      = 32,
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = 1,
  parameter int CNT_W     = 32,
  localparam int GW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_PORTS-1:0]      req_valid,
  output logic [NUM_PORTS-1:0]      req_ready,
  input  logic [NUM_PORTS*XLEN-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]      req_we,
  input  logic [NUM_PORTS*2-1:0]    req_size,
  input  logic [NUM_PORTS*XLEN-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]      rsp_valid,
  output logic [XLEN-1:0]           rsp_rdata,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [XLEN-1:0]           mem_addr,
  output logic                      mem_we,
  output logic [1:0]                mem_size,
  output logic [XLEN-1:0]           mem_wdata,
  input  logic                      mem_rsp_valid,
  input  logic [XLEN-1:0]           mem_rsp_rdata,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic                      protocol_err,
  output logic [NUM_PORTS*CNT_W-1:0] perf_grant_cnt,
  output logic [NUM_PORTS*CNT_W-1:0] perf_stall_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  state_e                 state_q, state_d;
  logic [GW-1:0]          grant_id_q, grant_id_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic [XLEN-1:0]        addr_q, addr_d;
  logic                   we_q, we_d;
  logic [1:0]             size_q, size_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;
  logic                   mem_req_valid_q, mem_req_valid_d;
  logic [NUM_PORTS-1:0]   rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                   protocol_err_q, protocol_err_d;

  int                     base_idx;
  logic [GW-1:0]          scan_idx;
  logic [GW-1:0]          win_idx;
  logic                   win_found;

  // Search starts at 0 for fixed priority, or just past the last grant for round-robin.
  always_comb begin
    base_idx  = (ARB_MODE == 0) ? 0 : (int'(last_grant_q) + 1) % NUM_PORTS;
    scan_idx  = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = GW'((base_idx + k) % NUM_PORTS);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && reset_n && win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_id_d      = grant_id_q;
    last_grant_d    = last_grant_q;
    addr_d          = addr_q;
    we_d            = we_q;
    size_d          = size_q;
    wdata_d         = wdata_q;
    mem_req_valid_d = mem_req_valid_q;
    rsp_valid_d     = '0;
    rsp_rdata_d     = rsp_rdata_q;
    protocol_err_d  = protocol_err_q;
    case (state_q)
      IDLE: begin
        if (mem_rsp_valid) begin
          protocol_err_d = 1'b1;
        end
        if (win_found) begin
          addr_d          = req_addr[int'(win_idx)*XLEN +: XLEN];
          we_d            = req_we[win_idx];
          size_d          = req_size[int'(win_idx)*2 +: 2];
          wdata_d         = req_wdata[int'(win_idx)*XLEN +: XLEN];
          grant_id_d      = win_idx;
          last_grant_d    = win_idx;
          mem_req_valid_d = 1'b1;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_rsp_valid) begin
          protocol_err_d = 1'b1;
        end
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          rsp_valid_d[grant_id_q] = 1'b1;
          rsp_rdata_d             = mem_rsp_rdata;
          state_d                 = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      grant_id_q      <= '0;
      last_grant_q    <= GW'(NUM_PORTS - 1);
      addr_q          <= '0;
      we_q            <= 1'b0;
      size_q          <= '0;
      wdata_q         <= '0;
      mem_req_valid_q <= 1'b0;
      rsp_valid_q     <= '0;
      rsp_rdata_q     <= '0;
      protocol_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_id_q      <= grant_id_d;
      last_grant_q    <= last_grant_d;
      addr_q          <= addr_d;
      we_q            <= we_d;
      size_q          <= size_d;
      wdata_q         <= wdata_d;
      mem_req_valid_q <= mem_req_valid_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      protocol_err_q  <= protocol_err_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign mem_size      = size_q;
  assign mem_wdata     = wdata_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign protocol_err  = protocol_err_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = (NUM_PORTS == 1) ? '0 : grant_id_q;

`ifdef MEM_ARB_PERF_EN
  logic [NUM_PORTS*CNT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [NUM_PORTS*CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_valid[i] && req_ready[i] && (grant_cnt_q[i*CNT_W +: CNT_W] != '1)) begin
        grant_cnt_d[i*CNT_W +: CNT_W] = grant_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
      if (req_valid[i] && !req_ready[i] && (stall_cnt_q[i*CNT_W +: CNT_W] != '1)) begin
        stall_cnt_d[i*CNT_W +: CNT_W] = stall_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_grant_cnt = grant_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_grant_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter_n.sv
// Bench for mem_req_arbiter_n: a 3-port round-robin instance against a transaction-level model,
// and a 2-port fixed-priority instance with 4-bit counters against an arithmetic schedule.

module tb_mem_req_arbiter_n;
  localparam int XL  = 32;
  localparam int RN  = 3;
  localparam int FN  = 2;
  localparam int FCW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [RN-1:0]    rr_req_valid, rr_req_ready, rr_req_we, rr_rsp_valid;
  logic [RN*XL-1:0] rr_req_addr, rr_req_wdata;
  logic [RN*2-1:0]  rr_req_size;
  logic [XL-1:0]    rr_rsp_rdata, rr_mem_addr, rr_mem_wdata, rr_mem_rsp_rdata;
  logic             rr_mem_req_valid, rr_mem_req_ready, rr_mem_we, rr_mem_rsp_valid;
  logic             rr_busy, rr_protocol_err;
  logic [1:0]       rr_mem_size, rr_grant_id;
  logic [RN*32-1:0] rr_perf_grant_cnt, rr_perf_stall_cnt;

  logic [FN-1:0]    fp_req_valid, fp_req_ready, fp_req_we, fp_rsp_valid;
  logic [FN*XL-1:0] fp_req_addr, fp_req_wdata;
  logic [FN*2-1:0]  fp_req_size;
  logic [XL-1:0]    fp_rsp_rdata, fp_mem_addr, fp_mem_wdata, fp_mem_rsp_rdata;
  logic             fp_mem_req_valid, fp_mem_we, fp_mem_rsp_valid;
  logic             fp_busy, fp_protocol_err;
  logic [1:0]       fp_mem_size;
  logic [0:0]       fp_grant_id;
  logic [FN*FCW-1:0] fp_perf_grant_cnt, fp_perf_stall_cnt;

  mem_req_arbiter_n #(.XLEN(XL), .NUM_PORTS(RN), .ARB_MODE(1), .CNT_W(32)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .req_valid(rr_req_valid), .req_ready(rr_req_ready), .req_addr(rr_req_addr),
    .req_we(rr_req_we), .req_size(rr_req_size), .req_wdata(rr_req_wdata),
    .rsp_valid(rr_rsp_valid), .rsp_rdata(rr_rsp_rdata),
    .mem_req_valid(rr_mem_req_valid), .mem_req_ready(rr_mem_req_ready),
    .mem_addr(rr_mem_addr), .mem_we(rr_mem_we), .mem_size(rr_mem_size), .mem_wdata(rr_mem_wdata),
    .mem_rsp_valid(rr_mem_rsp_valid), .mem_rsp_rdata(rr_mem_rsp_rdata),
    .grant_id(rr_grant_id), .busy(rr_busy), .protocol_err(rr_protocol_err),
    .perf_grant_cnt(rr_perf_grant_cnt), .perf_stall_cnt(rr_perf_stall_cnt)
  );

  mem_req_arbiter_n #(.XLEN(XL), .NUM_PORTS(FN), .ARB_MODE(0), .CNT_W(FCW)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .req_valid(fp_req_valid), .req_ready(fp_req_ready), .req_addr(fp_req_addr),
    .req_we(fp_req_we), .req_size(fp_req_size), .req_wdata(fp_req_wdata),
    .rsp_valid(fp_rsp_valid), .rsp_rdata(fp_rsp_rdata),
    .mem_req_valid(fp_mem_req_valid), .mem_req_ready(1'b1),
    .mem_addr(fp_mem_addr), .mem_we(fp_mem_we), .mem_size(fp_mem_size), .mem_wdata(fp_mem_wdata),
    .mem_rsp_valid(fp_mem_rsp_valid), .mem_rsp_rdata(fp_mem_rsp_rdata),
    .grant_id(fp_grant_id), .busy(fp_busy), .protocol_err(fp_protocol_err),
    .perf_grant_cnt(fp_perf_grant_cnt), .perf_stall_cnt(fp_perf_stall_cnt)
  );

  // The fixed-priority instance's memory answers in the first waiting cycle.
  assign fp_mem_rsp_valid = fp_busy & ~fp_mem_req_valid;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int          m_phase, m_last, m_gid, m_port;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_size;
  logic        m_we, m_pend, m_err;
  int          grants[$];

  task automatic model_reset();
    m_phase = 0; m_last = RN - 1; m_gid = 0; m_port = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_size = '0;
    m_we = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    grants.delete();
  endtask

  function automatic int rr_pick(input logic [RN-1:0] v, input int last);
    int idx;
    for (int k = 1; k <= RN; k++) begin
      idx = (last + k) % RN;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // Called just after a rising edge; asserts reset for one edge and checks the async reset values.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_req_ready", 64'(rr_req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rr_rsp_valid), 64'(0));
    chk("rst_mem_req_valid", 64'(rr_mem_req_valid), 64'(0));
    chk("rst_grant_id", 64'(rr_grant_id), 64'(0));
    chk("rst_busy", 64'(rr_busy), 64'(0));
    chk("rst_protocol_err", 64'(rr_protocol_err), 64'(0));
    chk("rst_rsp_rdata", 64'(rr_rsp_rdata), 64'(0));
    chk("rst_mem_fields", {rr_mem_addr, rr_mem_wdata}, 64'(0));
    chk("rst_mem_we_size", 64'({rr_mem_we, rr_mem_size}), 64'(0));
    chk("rst_perf", 64'(rr_perf_grant_cnt | rr_perf_stall_cnt), 64'(0));
    chk("rst_fp_busy", 64'(fp_busy), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // One clock of the round-robin instance: drive, check against the model, advance the model.
  task automatic cyc(input logic [RN-1:0] v, input logic [RN-1:0] we, input logic [31:0] a0,
                     input logic mrdy, input logic mrsp, input logic [31:0] mdata);
    logic [RN-1:0] exp_ready;
    int w;
    rr_req_valid = v;
    rr_req_we    = we;
    for (int i = 0; i < RN; i++) begin
      rr_req_addr[i*XL +: XL]  = (i == 0) ? a0 : $urandom;
      rr_req_wdata[i*XL +: XL] = $urandom;
      rr_req_size[i*2 +: 2]    = 2'($urandom_range(0, 3));
    end
    rr_mem_req_ready = mrdy;
    rr_mem_rsp_valid = mrsp;
    rr_mem_rsp_rdata = mdata;
    @(negedge clk);
    w = rr_pick(v, m_last);
    exp_ready = '0;
    if (m_phase == 0 && w >= 0) exp_ready[w[1:0]] = 1'b1;
    chk("req_ready", 64'(rr_req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(rr_rsp_valid), m_pend ? (64'(1) << m_port) : 64'(0));
    chk("rsp_rdata", 64'(rr_rsp_rdata), 64'(m_rdata));
    chk("busy", 64'(rr_busy), 64'(m_phase != 0));
    chk("mem_req_valid", 64'(rr_mem_req_valid), 64'(m_phase == 1));
    chk("protocol_err", 64'(rr_protocol_err), 64'(m_err));
    if (m_phase == 1) begin
      chk("mem_addr", 64'(rr_mem_addr), 64'(m_addr));
      chk("mem_wdata", 64'(rr_mem_wdata), 64'(m_wdata));
      chk("mem_we_size", 64'({rr_mem_we, rr_mem_size}), 64'({m_we, m_size}));
    end
    if (m_phase != 0) chk("grant_id", 64'(rr_grant_id), 64'(m_gid));
    m_pend = 1'b0;
    case (m_phase)
      0: begin
        if (mrsp) m_err = 1'b1;
        if (w >= 0) begin
          m_last  = w;
          m_gid   = w;
          m_addr  = rr_req_addr[w*XL +: XL];
          m_wdata = rr_req_wdata[w*XL +: XL];
          m_we    = rr_req_we[w[1:0]];
          m_size  = rr_req_size[w*2 +: 2];
          m_phase = 1;
          grants.push_back(w);
        end
      end
      1: begin
        if (mrsp) m_err = 1'b1;
        if (mrdy) m_phase = 2;
      end
      default: begin
        if (mrsp) begin
          m_pend  = 1'b1;
          m_port  = m_gid;
          m_rdata = mdata;
          m_phase = 0;
        end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 10 && m_phase != 0; c++) begin
      cyc(3'b000, 3'($urandom), $urandom, 1'b1, m_phase == 2, $urandom);
    end
    cyc(3'b000, 3'($urandom), $urandom, 1'b1, 1'b0, $urandom);
    chk("drain_busy", 64'(rr_busy), 64'(0));
  endtask

  int   e_g[FN], e_s[FN];
  int   prev_w;
  logic [FN-1:0] fv, exp_rdy, exp_rsp;

  initial begin
    reset_n = 1'b0;
    rr_req_valid = '0; rr_req_we = '0; rr_req_addr = '0; rr_req_wdata = '0; rr_req_size = '0;
    rr_mem_req_ready = 1'b0; rr_mem_rsp_valid = 1'b0; rr_mem_rsp_rdata = '0;
    fp_req_valid = '0; fp_req_we = '0; fp_req_addr = '0; fp_req_wdata = '0; fp_req_size = '0;
    fp_mem_rsp_rdata = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Fixed priority: ports 0,1 valid for 18 cycles, then only port 1; zero downstream wait.
    for (int i = 0; i < FN; i++) begin
      e_g[i] = 0;
      e_s[i] = 0;
    end
    prev_w = -1;
    for (int k = 0; k < 30; k++) begin
      fv = (k < 18) ? 2'b11 : 2'b10;
      fp_req_valid = fv;
      fp_req_addr  = {$urandom, $urandom};
      fp_req_wdata = {$urandom, $urandom};
      fp_mem_rsp_rdata = 32'hA500_0000 + 32'(k);
      @(negedge clk);
      exp_rdy = (k % 3 == 0) ? (fv[0] ? 2'b01 : 2'b10) : 2'b00;
      exp_rsp = (k % 3 == 0 && prev_w >= 0) ? ((prev_w == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("fp_req_ready", 64'(fp_req_ready), 64'(exp_rdy));
      chk("fp_rsp_valid", 64'(fp_rsp_valid), 64'(exp_rsp));
      if (exp_rsp != 0) chk("fp_rsp_rdata", 64'(fp_rsp_rdata), 64'(32'hA500_0000 + 32'(k - 1)));
      for (int i = 0; i < FN; i++) begin
`ifdef MEM_ARB_PERF_EN
        chk("fp_grant_cnt", 64'(fp_perf_grant_cnt[i*FCW +: FCW]), 64'(e_g[i]));
        chk("fp_stall_cnt", 64'(fp_perf_stall_cnt[i*FCW +: FCW]), 64'(e_s[i]));
`else
        chk("fp_grant_cnt_off", 64'(fp_perf_grant_cnt[i*FCW +: FCW]), 64'(0));
        chk("fp_stall_cnt_off", 64'(fp_perf_stall_cnt[i*FCW +: FCW]), 64'(0));
`endif
      end
      if (k % 3 == 0) prev_w = fv[0] ? 0 : 1;
      for (int i = 0; i < FN; i++) begin
        if (exp_rdy[i]) e_g[i] = (e_g[i] < 15) ? e_g[i] + 1 : 15;
        if (fv[i] && !exp_rdy[i]) e_s[i] = (e_s[i] < 15) ? e_s[i] + 1 : 15;
      end
      @(posedge clk);
      #1;
    end
    fp_req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("fp_idle_busy", 64'(fp_busy), 64'(0));
    chk("fp_protocol_err", 64'(fp_protocol_err), 64'(0));

    // Single read of 0x100 answered with 0xDEADBEEF.
    do_reset();
    cyc(3'b001, 3'b000, 32'h100, 1'b1, 1'b0, 32'h0);
    cyc(3'b000, 3'b000, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(3'b000, 3'b000, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(3'b000, 3'b000, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("single_rsp_valid", 64'(rr_rsp_valid), 64'(3'b001));
    cyc(3'b000, 3'b000, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("single_rdata_hold", 64'(rr_rsp_rdata), 64'(32'hDEAD_BEEF));
    chk("single_busy", 64'(rr_busy), 64'(0));
    chk("single_rsp_once", 64'(rr_rsp_valid), 64'(0));

    // Downstream backpressure for 5 cycles with every port requesting.
    cyc(3'b010, 3'($urandom), $urandom, 1'b0, 1'b0, 32'h0);
    repeat (5) cyc(3'b111, 3'($urandom), $urandom, 1'b0, 1'b0, 32'h0);
    cyc(3'b111, 3'($urandom), $urandom, 1'b1, 1'b0, 32'h0);
    cyc(3'b000, 3'($urandom), $urandom, 1'b1, 1'b1, 32'h1357_2468);
    cyc(3'b000, 3'($urandom), $urandom, 1'b1, 1'b0, 32'h0);

    // Stray response in IDLE.
    cyc(3'b000, 3'($urandom), $urandom, 1'b1, 1'b1, 32'h5555_5555);
    cyc(3'b000, 3'($urandom), $urandom, 1'b1, 1'b0, 32'h0);
    cyc(3'b000, 3'($urandom), $urandom, 1'b1, 1'b0, 32'h0);
    chk("stray_err", 64'(rr_protocol_err), 64'(1));
    chk("stray_no_rsp", 64'(rr_rsp_valid), 64'(0));

    // Reset while waiting for a response, then a late response.
    cyc(3'b100, 3'($urandom), $urandom, 1'b1, 1'b0, 32'h0);
    cyc(3'b000, 3'($urandom), $urandom, 1'b1, 1'b0, 32'h0);
    cyc(3'b000, 3'($urandom), $urandom, 1'b1, 1'b0, 32'h0);
    chk("mid_wait_busy", 64'(rr_busy), 64'(1));
    do_reset();
    cyc(3'b000, 3'($urandom), $urandom, 1'b1, 1'b1, 32'h0BAD_0BAD);
    cyc(3'b000, 3'($urandom), $urandom, 1'b1, 1'b0, 32'h0);
    chk("late_err", 64'(rr_protocol_err), 64'(1));
    chk("late_no_rsp", 64'(rr_rsp_valid), 64'(0));
    do_reset();
    cyc(3'b001, 3'b000, 32'h200, 1'b1, 1'b0, 32'h0);
    cyc(3'b000, 3'b000, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(3'b000, 3'b000, 32'h0, 1'b1, 1'b1, 32'h1234_5678);
    cyc(3'b000, 3'b000, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("post_reset_rdata", 64'(rr_rsp_rdata), 64'(32'h1234_5678));

    // Round-robin fairness from reset with all ports valid.
    do_reset();
    for (int c = 0; c < 40 && grants.size() < 6; c++) begin
      cyc(3'b111, 3'($urandom), $urandom, 1'b1, m_phase == 2, $urandom);
    end
    chk("rr_count", 64'(grants.size()), 64'(6));
    for (int i = 0; i < 6 && i < grants.size(); i++) chk("rr_order", 64'(grants[i]), 64'(i % 3));
    drain();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      cyc(3'($urandom), 3'($urandom), $urandom, $urandom_range(0, 3) != 0,
          (m_phase == 2) && ($urandom_range(0, 1) == 1), $urandom);
    end
    drain();
`ifndef MEM_ARB_PERF_EN
    for (int i = 0; i < RN; i++) begin
      chk("rr_perf_off", 64'(rr_perf_grant_cnt[i*32 +: 32] | rr_perf_stall_cnt[i*32 +: 32]), 64'(0));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
